// File: rtl/id_issue_buffer.sv
// Multi-lane decode-to-issue buffer: circular queue accepting up to NR_LANES
// entries per cycle and presenting the oldest NR_LANES entries in order.
module id_issue_buffer #(
   parameter int NR_LANES   = 2,
   parameter int DEPTH      = 8,
   parameter int DATA_WIDTH = 64,
   parameter int CF_STOP    = 1
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             flush_i,
   input  logic [NR_LANES*DATA_WIDTH-1:0]   in_data_i,
   input  logic [NR_LANES-1:0]              in_is_cf_i,
   input  logic [NR_LANES-1:0]              in_valid_i,
   output logic [NR_LANES-1:0]              in_ready_o,
   output logic [NR_LANES*DATA_WIDTH-1:0]   out_data_o,
   output logic [NR_LANES-1:0]              out_is_cf_o,
   output logic [NR_LANES-1:0]              out_valid_o,
   input  logic [NR_LANES-1:0]              out_ack_i,
   output logic [$clog2(DEPTH+1)-1:0]       count_o,
   output logic                             full_o,
   output logic                             empty_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   // Sums stay below 2*DEPTH, so one conditional subtract is an exact modulo.
   function automatic logic [PW-1:0] wrap(input logic [PW:0] a);
      logic [PW:0] s;
      s = (a >= (PW+1)'(DEPTH)) ? a - (PW+1)'(DEPTH) : a;
      return s[PW-1:0];
   endfunction

   logic [DATA_WIDTH:0]  r_mem [DEPTH];
   logic [PW-1:0]        r_rd;
   logic [PW-1:0]        r_wr;
   logic [CW-1:0]        r_count;

   logic [CW-1:0]        w_free;
   logic [CW-1:0]        w_npush;
   logic [CW-1:0]        w_npop;
   logic [NR_LANES-1:0]  w_ready;
   logic [NR_LANES-1:0]  w_valid;
   logic                 w_ok;
   logic                 w_run;
   logic [PW-1:0]        w_ridx;

   // Space comes from the registered count only: no ack-to-ready path.
   always_comb begin
      w_free  = CW'(DEPTH) - r_count;
      w_ok    = !flush_i;
      w_ready = '0;
      w_npush = '0;
      for (int i = 0; i < NR_LANES; i++) begin
         w_ok       = w_ok & in_valid_i[i] & (CW'(i) < w_free);
         w_ready[i] = w_ok;
         if (w_ok) w_npush = CW'(i + 1);
         if (CF_STOP != 0) w_ok = w_ok & ~in_is_cf_i[i];
      end
   end

   always_comb begin
      w_valid     = '0;
      w_ridx      = '0;
      out_data_o  = '0;
      out_is_cf_o = '0;
      for (int j = 0; j < NR_LANES; j++) begin
         w_ridx     = wrap({1'b0, r_rd} + (PW+1)'(j));
         w_valid[j] = CW'(j) < r_count;
         if (w_valid[j]) begin
            out_data_o[j*DATA_WIDTH +: DATA_WIDTH] = r_mem[w_ridx][DATA_WIDTH-1:0];
            out_is_cf_o[j]                         = r_mem[w_ridx][DATA_WIDTH];
         end
      end
   end

   always_comb begin
      w_run  = !flush_i;
      w_npop = '0;
      for (int j = 0; j < NR_LANES; j++) begin
         w_run = w_run & out_ack_i[j] & w_valid[j];
         if (w_run) w_npop = CW'(j + 1);
      end
   end

   always_ff @(posedge clk_i) begin
      for (int i = 0; i < NR_LANES; i++) begin
         if (w_ready[i])
            r_mem[wrap({1'b0, r_wr} + (PW+1)'(i))] <= {in_is_cf_i[i], in_data_i[i*DATA_WIDTH +: DATA_WIDTH]};
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
      end else if (flush_i) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
      end else begin
         r_rd    <= wrap({1'b0, r_rd} + (PW+1)'(w_npop));
         r_wr    <= wrap({1'b0, r_wr} + (PW+1)'(w_npush));
         r_count <= r_count + w_npush - w_npop;
      end
   end

   assign in_ready_o  = w_ready;
   assign out_valid_o = w_valid;
   assign count_o     = r_count;
   assign full_o      = (r_count == CW'(DEPTH));
   assign empty_o     = (r_count == '0);

endmodule

// File: tb/tb_id_issue_buffer.sv
// Bench for id_issue_buffer: three configurations share one input stream and
// are each compared against an ordered-list model of the queue.
module tb_id_issue_buffer;

   localparam int DW = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic [31:0] in_data;
   logic [1:0]  in_cf;
   logic [1:0]  in_valid;
   logic [1:0]  ack;

   // dut 0: DEPTH=4 CF_STOP=1, dut 1: DEPTH=4 CF_STOP=0, dut 2: DEPTH=3 CF_STOP=1
   logic [1:0]  rdy0, rdy1, rdy2;
   logic [31:0] od0, od1, od2;
   logic [1:0]  oc0, oc1, oc2;
   logic [1:0]  ov0, ov1, ov2;
   logic [2:0]  cnt0, cnt1;
   logic [1:0]  cnt2;
   logic        full0, full1, full2, emp0, emp1, emp2;

   int ncmp = 0;
   int nfail = 0;

   // Model: per dut, an ordered list (index 0 = oldest) of {cf, data}.
   logic [DW:0] mq [3][8];
   int          mcnt [3];
   int          mdepth [3] = '{4, 4, 3};
   bit          mcfs [3]   = '{1'b1, 1'b0, 1'b1};

   always #5 clk = ~clk;

   id_issue_buffer #(.NR_LANES(2), .DEPTH(4), .DATA_WIDTH(DW), .CF_STOP(1)) u_d0 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_data_i(in_data),
      .in_is_cf_i(in_cf), .in_valid_i(in_valid), .in_ready_o(rdy0),
      .out_data_o(od0), .out_is_cf_o(oc0), .out_valid_o(ov0), .out_ack_i(ack),
      .count_o(cnt0), .full_o(full0), .empty_o(emp0));

   id_issue_buffer #(.NR_LANES(2), .DEPTH(4), .DATA_WIDTH(DW), .CF_STOP(0)) u_d1 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_data_i(in_data),
      .in_is_cf_i(in_cf), .in_valid_i(in_valid), .in_ready_o(rdy1),
      .out_data_o(od1), .out_is_cf_o(oc1), .out_valid_o(ov1), .out_ack_i(ack),
      .count_o(cnt1), .full_o(full1), .empty_o(emp1));

   id_issue_buffer #(.NR_LANES(2), .DEPTH(3), .DATA_WIDTH(DW), .CF_STOP(1)) u_d2 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_data_i(in_data),
      .in_is_cf_i(in_cf), .in_valid_i(in_valid), .in_ready_o(rdy2),
      .out_data_o(od2), .out_is_cf_o(oc2), .out_valid_o(ov2), .out_ack_i(ack),
      .count_o(cnt2), .full_o(full2), .empty_o(emp2));

   task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s[dut%0d]: observed %0h expected %0h", tag, k, obs, exp);
      end
   endtask

   // Lanes accepted: a valid prefix that fits in free space, cut after a cf lane when enabled.
   function automatic logic [1:0] exp_ready(input int k);
      logic [1:0] r = 2'b00;
      int free = mdepth[k] - mcnt[k];
      if (flush) return 2'b00;
      for (int i = 0; i < 2; i++) begin
         if (!in_valid[i] || i >= free) break;
         r[i] = 1'b1;
         if (mcfs[k] && in_cf[i]) break;
      end
      return r;
   endfunction

   task automatic check_dut(input int k, input logic [1:0] rdy, input logic [1:0] ov,
                            input logic [31:0] od, input logic [1:0] oc,
                            input logic [3:0] cnt, input logic full, input logic emp);
      logic [1:0]  e_v  = 2'b00;
      logic [1:0]  e_c  = 2'b00;
      logic [31:0] e_d  = '0;
      for (int j = 0; j < 2; j++) begin
         if (j < mcnt[k]) begin
            e_v[j]          = 1'b1;
            e_c[j]          = mq[k][j][DW];
            e_d[j*DW +: DW] = mq[k][j][DW-1:0];
         end
      end
      chk("in_ready", k, 32'(rdy), 32'(exp_ready(k)));
      chk("out_valid", k, 32'(ov), 32'(e_v));
      chk("out_data", k, od, e_d);
      chk("out_is_cf", k, 32'(oc), 32'(e_c));
      chk("count", k, 32'(cnt), 32'(mcnt[k]));
      chk("full", k, 32'(full), 32'(mcnt[k] == mdepth[k]));
      chk("empty", k, 32'(emp), 32'(mcnt[k] == 0));
   endtask

   task automatic model_update(input int k);
      logic [1:0] acc = exp_ready(k);
      int npop = 0;
      if (!rst_n || flush) begin
         mcnt[k] = 0;
         return;
      end
      for (int j = 0; j < 2; j++) begin
         if (ack[j] && j < mcnt[k]) npop++;
         else break;
      end
      for (int i = 0; i < mcnt[k] - npop; i++) mq[k][i] = mq[k][i + npop];
      mcnt[k] -= npop;
      for (int i = 0; i < 2; i++) begin
         if (acc[i]) begin
            mq[k][mcnt[k]] = {in_cf[i], in_data[i*DW +: DW]};
            mcnt[k]++;
         end
      end
   endtask

   // Apply inputs, check combinational outputs mid-cycle, then advance model and clock.
   task automatic step(input logic [1:0] v, input logic [1:0] cf, input logic [31:0] d,
                       input logic [1:0] a, input logic fl, input logic rn);
      in_valid = v; in_cf = cf; in_data = d; ack = a; flush = fl; rst_n = rn;
      @(negedge clk);
      check_dut(0, rdy0, ov0, od0, oc0, {1'b0, cnt0}, full0, emp0);
      check_dut(1, rdy1, ov1, od1, oc1, {1'b0, cnt1}, full1, emp1);
      check_dut(2, rdy2, ov2, od2, oc2, {2'b0, cnt2}, full2, emp2);
      for (int k = 0; k < 3; k++) model_update(k);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_data = '0; in_cf = '0; in_valid = '0; ack = '0;
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) mcnt[k] = 0;

      // Reset state, then fill: A,B then C,D; then full with acks
      step(2'b00, 2'b00, 32'h0, 2'b00, 1'b0, 1'b1);
      step(2'b11, 2'b00, 32'h000B_000A, 2'b00, 1'b0, 1'b1);
      step(2'b11, 2'b00, 32'h000D_000C, 2'b00, 1'b0, 1'b1);
      step(2'b11, 2'b00, 32'h000F_000E, 2'b11, 1'b0, 1'b1);
      step(2'b11, 2'b00, 32'h0011_0010, 2'b00, 1'b0, 1'b1);
      // Ack prefix: 10 pops nothing, 01 pops one
      step(2'b00, 2'b00, 32'h0, 2'b10, 1'b0, 1'b1);
      step(2'b00, 2'b00, 32'h0, 2'b01, 1'b0, 1'b1);
      // Flush while pushing and acking
      step(2'b11, 2'b00, 32'h0013_0012, 2'b11, 1'b1, 1'b1);
      // cf on lane 0 into empty queue
      step(2'b11, 2'b01, 32'h0015_0014, 2'b00, 1'b0, 1'b1);
      // Valid gap
      step(2'b10, 2'b00, 32'h0017_0016, 2'b00, 1'b0, 1'b1);
      // Wrap traffic: push 2, pop 2, push 2
      step(2'b11, 2'b00, 32'h0019_0018, 2'b11, 1'b0, 1'b1);
      step(2'b00, 2'b00, 32'h0, 2'b11, 1'b0, 1'b1);
      step(2'b11, 2'b00, 32'h001B_001A, 2'b01, 1'b0, 1'b1);
      step(2'b11, 2'b00, 32'h001D_001C, 2'b00, 1'b0, 1'b1);
      // Reset mid-operation
      step(2'b11, 2'b00, 32'h001F_001E, 2'b00, 1'b0, 1'b0);
      step(2'b00, 2'b00, 32'h0, 2'b00, 1'b0, 1'b1);

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         step(2'($urandom), {($urandom_range(3) == 0), ($urandom_range(3) == 0)},
              32'($urandom), 2'($urandom),
              ($urandom_range(31) == 0), ($urandom_range(63) != 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
